// File: rtl/tiny_cpu_pkg.sv
// Shared widths and pairing-state encoding for the instruction/data bus merger.
package tiny_cpu_pkg;

  localparam int unsigned INSTR_W = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned WORD_W  = INSTR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HAVE_INS,
    ST_HAVE_DATA,
    ST_PAIRED
  } pair_state_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic [INSTR_W-1:0] ins,
                                                  input logic [DATA_W-1:0]  dat);
    return {ins, dat};
  endfunction

endpackage

// File: rtl/bus_merge_fifo.sv
// Small FIFO of packed words, each tagged with its program address.
module bus_merge_fifo
  import tiny_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_push_word,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic              i_pop,
  output logic              o_valid,
  output logic              o_full,
  output logic [WORD_W-1:0] o_word,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] r_word [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && o_valid && !i_flush;
  assign w_push_ok = i_push && (!o_full || w_pop_ok) && !i_flush;
  // Outputs read as zero while empty so stale entries never show on the bus.
  assign o_word    = o_valid ? r_word[r_rd_ptr] : '0;
  assign o_addr    = o_valid ? r_addr[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_word[i] <= '0;
        r_addr[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_word[r_wr_ptr] <= i_push_word;
        r_addr[r_wr_ptr] <= i_push_addr;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_merge.sv
// Pairs instruction nibbles with data bytes into 12-bit program words,
// tags each with a wrapping address and buffers them for the downstream bus.
module bus_merge
  import tiny_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  output logic               instr_ready,
  input  logic               data_valid,
  input  logic [DATA_W-1:0]  data,
  output logic               data_ready,
  output logic               word_valid,
  output logic [WORD_W-1:0]  bus_word,
  output logic [ADDR_W-1:0]  word_addr,
  input  logic               word_ready,
  output logic               addr_wrap
);

  pair_state_t        r_state;
  pair_state_t        w_next;
  logic [INSTR_W-1:0] r_ins;
  logic [DATA_W-1:0]  r_data;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_wrap;
  logic               w_instr_xfer;
  logic               w_data_xfer;
  logic               w_pop;
  logic               w_push;
  logic               w_full;

  assign w_instr_xfer = instr_valid && instr_ready;
  assign w_data_xfer  = data_valid && data_ready;
  assign w_pop        = word_valid && word_ready;
  // A full buffer still accepts the push when the head leaves in the same cycle.
  assign w_push       = (r_state == ST_PAIRED) && !clear && (!w_full || w_pop);
  assign addr_wrap    = r_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_instr_xfer && w_data_xfer) w_next = ST_PAIRED;
          else if (w_instr_xfer)           w_next = ST_HAVE_INS;
          else if (w_data_xfer)            w_next = ST_HAVE_DATA;
        end
        ST_HAVE_INS:  if (w_data_xfer)  w_next = ST_PAIRED;
        ST_HAVE_DATA: if (w_instr_xfer) w_next = ST_PAIRED;
        ST_PAIRED:    if (w_push)       w_next = ST_IDLE;
        default:      w_next = ST_IDLE;
      endcase
    end
  end

  // Readies are gated by rst_n so they drop the instant reset asserts.
  always_comb begin
    instr_ready = 1'b0;
    data_ready  = 1'b0;
    if (rst_n && !clear) begin
      case (r_state)
        ST_IDLE: begin
          instr_ready = 1'b1;
          data_ready  = 1'b1;
        end
        ST_HAVE_INS:  data_ready  = 1'b1;
        ST_HAVE_DATA: instr_ready = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins  <= '0;
      r_data <= '0;
    end else if (clear) begin
      r_ins  <= '0;
      r_data <= '0;
    end else begin
      if (w_instr_xfer) r_ins  <= instruction;
      if (w_data_xfer)  r_data <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else if (clear) begin
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_push && (r_addr == '1);
      if (w_push) r_addr <= r_addr + 1'b1;
    end
  end

  bus_merge_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (clear),
    .i_push      (w_push),
    .i_push_word (pack_word(r_ins, r_data)),
    .i_push_addr (r_addr),
    .i_pop       (word_ready),
    .o_valid     (word_valid),
    .o_full      (w_full),
    .o_word      (bus_word),
    .o_addr      (word_addr)
  );

endmodule

// File: tb/tb_bus_merge.sv
// Scoreboard bench for bus_merge: expected words queued as pairs are offered,
// checked in order as the DUT hands them downstream.
module tb_bus_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        instr_valid;
  logic [3:0]  instruction;
  logic        instr_ready;
  logic        data_valid;
  logic [7:0]  data;
  logic        data_ready;
  logic        word_valid;
  logic [11:0] bus_word;
  logic [7:0]  word_addr;
  logic        word_ready;
  logic        addr_wrap;

  typedef struct {
    logic [11:0] word;
    logic [7:0]  addr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_addr = '0;
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         wrap_cnt = 0;

  bus_merge #(.ADDR_W(8), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_ready (instr_ready),
    .data_valid  (data_valid),
    .data        (data),
    .data_ready  (data_ready),
    .word_valid  (word_valid),
    .bus_word    (bus_word),
    .word_addr   (word_addr),
    .word_ready  (word_ready),
    .addr_wrap   (addr_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input logic [3:0] ins, input logic [7:0] dat);
    exp_t e;
    e.word = {ins, dat};
    e.addr = exp_addr;
    sb.push_back(e);
    exp_addr = exp_addr + 8'd1;
  endtask

  // Offers the selected operands and holds each until its handshake completes.
  task automatic send(input logic [3:0] ins, input logic [7:0] dat, input bit do_i, input bit do_d);
    bit pend_i = do_i;
    bit pend_d = do_d;
    bit ti, td;
    int n = 0;
    instruction = ins;
    data        = dat;
    instr_valid = do_i;
    data_valid  = do_d;
    while ((pend_i || pend_d) && n < 50) begin
      @(negedge clk);
      ti = pend_i && instr_ready;
      td = pend_d && data_ready;
      @(posedge clk); #1;
      if (ti) begin pend_i = 0; instr_valid = 1'b0; end
      if (td) begin pend_d = 0; data_valid  = 1'b0; end
      n++;
    end
    if (pend_i || pend_d) begin
      check("send_timeout", 32'(n), 32'd0);
      instr_valid = 1'b0;
      data_valid  = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge clk);
    check("clear_instr_ready", 32'(instr_ready), 32'd0);
    check("clear_data_ready",  32'(data_ready),  32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    sb.delete();
    exp_addr = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bus_word",  32'(bus_word),  32'(e.word));
        check("word_addr", 32'(word_addr), 32'(e.addr));
      end
    end
    if (addr_wrap) wrap_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; instr_valid = 1'b0; data_valid = 1'b0;
    instruction = '0; data = '0; word_ready = 1'b0;
    #12;
    check("rst_word_valid",  32'(word_valid),  32'd0);
    check("rst_bus_word",    32'(bus_word),    32'd0);
    check("rst_word_addr",   32'(word_addr),   32'd0);
    check("rst_addr_wrap",   32'(addr_wrap),   32'd0);
    check("rst_instr_ready", 32'(instr_ready), 32'd0);
    check("rst_data_ready",  32'(data_ready),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_instr_ready", 32'(instr_ready), 32'd1);
    check("post_rst_data_ready",  32'(data_ready),  32'd1);

    // Both operands together: word two cycles later, for one cycle.
    word_ready = 1'b1;
    send(4'hA, 8'h5C, 1, 1);
    sb_push(4'hA, 8'h5C);
    @(negedge clk); check("lat_cycle1", 32'(word_valid), 32'd0);
    @(negedge clk); check("lat_cycle2", 32'(word_valid), 32'd1);
    @(negedge clk); check("lat_cycle3", 32'(word_valid), 32'd0);
    @(posedge clk); #1;

    // Data first, instruction three cycles later.
    send(4'h0, 8'h01, 0, 1);
    repeat (3) begin
      @(negedge clk);
      check("have_data_data_ready",  32'(data_ready),  32'd0);
      check("have_data_instr_ready", 32'(instr_ready), 32'd1);
    end
    @(posedge clk); #1;
    send(4'h3, 8'h00, 1, 0);
    sb_push(4'h3, 8'h01);
    drain();

    // Backpressure: two words buffered, third pair stuck in PAIRED.
    clear_pulse();
    word_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(4'(i + 1), 8'(8'h10 + i), 1, 1);
      sb_push(4'(i + 1), 8'(8'h10 + i));
    end
    repeat (4) @(negedge clk);
    check("stuck_instr_ready", 32'(instr_ready), 32'd0);
    check("stuck_data_ready",  32'(data_ready),  32'd0);
    check("stuck_word_valid",  32'(word_valid),  32'd1);
    check("stuck_head_word",   32'(bus_word),    32'(sb[0].word));
    @(posedge clk); #1;
    word_ready = 1'b1;
    drain();

    // Address wrap across 257 pushes.
    clear_pulse();
    wrap_cnt = 0;
    for (int i = 0; i < 257; i++) begin
      logic [3:0] ri;
      logic [7:0] rd;
      ri = 4'($urandom_range(0, 15));
      rd = 8'($urandom_range(0, 255));
      send(ri, rd, 1, 1);
      sb_push(ri, rd);
    end
    drain();
    check("wrap_pulse_cycles", 32'(wrap_cnt), 32'd1);

    // clear while holding an instruction and one buffered word.
    word_ready = 1'b0;
    send(4'h7, 8'h77, 1, 1);
    sb_push(4'h7, 8'h77);
    repeat (2) @(posedge clk); #1;
    send(4'h9, 8'h00, 1, 0);
    @(negedge clk);
    check("have_ins_instr_ready", 32'(instr_ready), 32'd0);
    check("have_ins_data_ready",  32'(data_ready),  32'd1);
    check("pre_clear_word_valid", 32'(word_valid),  32'd1);
    @(posedge clk); #1;
    clear_pulse();
    @(negedge clk);
    check("post_clear_word_valid",  32'(word_valid),  32'd0);
    check("post_clear_instr_ready", 32'(instr_ready), 32'd1);
    check("post_clear_data_ready",  32'(data_ready),  32'd1);
    @(posedge clk); #1;
    word_ready = 1'b1;
    send(4'hB, 8'hE4, 1, 1);
    sb_push(4'hB, 8'hE4);
    drain();

    // Asynchronous reset while stuck in PAIRED with a full buffer.
    word_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(4'hC, 8'(8'h40 + i), 1, 1);
      sb_push(4'hC, 8'(8'h40 + i));
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_word_valid",  32'(word_valid),  32'd0);
    check("arst_bus_word",    32'(bus_word),    32'd0);
    check("arst_word_addr",   32'(word_addr),   32'd0);
    check("arst_addr_wrap",   32'(addr_wrap),   32'd0);
    check("arst_instr_ready", 32'(instr_ready), 32'd0);
    check("arst_data_ready",  32'(data_ready),  32'd0);
    sb.delete();
    exp_addr = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_rel_instr_ready", 32'(instr_ready), 32'd1);
    check("arst_rel_data_ready",  32'(data_ready),  32'd1);
    word_ready = 1'b1;
    send(4'h5, 8'hA1, 1, 1);
    sb_push(4'h5, 8'hA1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
